// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one TX FIFO write port among NREQ byte-stream requesters.
//   Round-robin arbitration with packet lock: once granted, a requester keeps
//   the port until its last byte, MAXBURST bytes, or IDLE_TO cycles with no
//   byte offered. Byte transfer is a zero-latency valid/ack handshake.
//
// Ports
//   PCLK        clock
//   PRESET      synchronous reset, active-high
//   req_valid   [NREQ]    requester i offers a byte on req_data[8i+:8]
//   req_data    [8*NREQ]  packed request bytes
//   req_last    [NREQ]    offered byte ends requester i's packet
//   req_ack     [NREQ]    one-hot, byte from requester i accepted this cycle
//   fifo_full             TX FIFO full
//   fifo_wr               TX FIFO write strobe
//   fifo_wdata  [8]       TX FIFO write data (grantee lane)
//   grant_id    [3]       current grantee, meaningful while busy=1
//   busy                  a grant is held
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAXBURST = 16,
    parameter int IDLE_TO  = 32
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ack,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [7:0]        fifo_wdata,
    output logic [2:0]        grant_id,
    output logic              busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } state_t;

    state_t                 state;
    logic [IW-1:0]          gnt;
    logic [IW-1:0]          rr_ptr;
    logic [7:0]             burst_cnt;
    logic [7:0]             idle_cnt;

    logic [NREQ-1:0][7:0]   lane_data;
    logic [NREQ-1:0]        gsel;
    logic [IW-1:0]          winner;
    logic                   any_req;
    logic [IW:0]            scan_idx;
    logic                   gnt_valid;
    logic                   gnt_last;
    logic [7:0]             gnt_data;
    logic                   xfer;
    logic [IW-1:0]          rr_next;
    logic                   burst_end;
    logic                   idle_end;

    assign lane_data = req_data;

    // Per-lane grant decode; ack and data muxing are built from these one-hot selects.
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign gsel[i]    = (gnt == IW'(i));
        assign req_ack[i] = xfer & gsel[i];
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (gsel[i]) begin
                gnt_valid = req_valid[i];
                gnt_last  = req_last[i];
                gnt_data  = lane_data[i];
            end
        end
    end

    // Rotating-priority search starting at rr_ptr. The scan runs from the
    // farthest offset back to rr_ptr so the nearest valid requester is the
    // last assignment and therefore the winner.
    always_comb begin
        winner   = rr_ptr;
        any_req  = 1'b0;
        scan_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr} + (IW+1)'(k);
            if (scan_idx >= (IW+1)'(NREQ))
                scan_idx = scan_idx - (IW+1)'(NREQ);
            if (req_valid[scan_idx[IW-1:0]]) begin
                winner  = scan_idx[IW-1:0];
                any_req = 1'b1;
            end
        end
    end

    // Reset gates the strobe so nothing is accepted while the grant is being dropped;
    // the requester keeps any byte it was offering.
    assign xfer       = (state == ST_XFER) & gnt_valid & ~fifo_full & ~PRESET;
    assign fifo_wr    = xfer;
    assign fifo_wdata = gnt_data;
    assign grant_id   = 3'(gnt);

    assign rr_next   = (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;
    assign burst_end = (burst_cnt == 8'(MAXBURST - 1));
    assign idle_end  = (idle_cnt == 8'(IDLE_TO - 1));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            gnt       <= '0;
            burst_cnt <= 8'd0;
            idle_cnt  <= 8'd0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt       <= winner;
                        burst_cnt <= 8'd0;
                        idle_cnt  <= 8'd0;
                        busy      <= 1'b1;
                        state     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (xfer) begin
                        // Last byte and burst limit on the same byte collapse to one release.
                        if (gnt_last || burst_end) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            rr_ptr    <= rr_next;
                            burst_cnt <= 8'd0;
                            idle_cnt  <= 8'd0;
                        end else begin
                            burst_cnt <= burst_cnt + 8'd1;
                            idle_cnt  <= 8'd0;
                        end
                    end else if (!gnt_valid) begin
                        if (idle_end) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            rr_ptr    <= rr_next;
                            burst_cnt <= 8'd0;
                            idle_cnt  <= 8'd0;
                        end else begin
                            idle_cnt <= idle_cnt + 8'd1;
                        end
                    end
                    // Valid but FIFO full: pure backpressure, counters hold.
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
